// File: rtl/acia_rx_fifo.sv
// rtl/acia_rx_fifo.sv - ACIA serial receiver with 16x majority-vote sampling and FWFT receive FIFO
module acia_rx_fifo #(
    parameter int DIVW    = 16,
    parameter int FIFO_AW = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rx_serial,
    input  logic [DIVW-1:0]    cfg_div,
    input  logic [1:0]         cfg_bits,
    input  logic [1:0]         cfg_par,
    input  logic               rd_en,
    output logic [7:0]         rd_dat,
    output logic               rd_ferr,
    output logic               rd_perr,
    output logic               rd_brk,
    output logic               empty,
    output logic [FIFO_AW:0]   count,
    output logic               overrun,
    input  logic               ovr_clr
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRKWAIT} state_t;

    localparam logic [FIFO_AW:0] DEPTH = (FIFO_AW+1)'(2**FIFO_AW);

    state_t             state;
    logic               sync1, sync2;
    logic [DIVW-1:0]    div_cnt, div_l;
    logic [1:0]         bits_l, par_l;
    logic [3:0]         phase;
    logic               s7, s8;
    logic [2:0]         bit_idx;
    logic [7:0]         shreg;
    logic               par_acc, any_one;
    logic               push;
    logic [10:0]        push_word;   // {data, brk, ferr, perr}

    logic               tick, mid, maj;
    logic [1:0]         shamt;
    logic [7:0]         data_w;

    assign tick  = (state != IDLE) && (div_cnt == '0);
    assign mid   = tick && (phase == 4'd9);
    assign maj   = (s7 & s8) | (s7 & sync2) | (s8 & sync2);
    assign shamt = 2'd3 - bits_l;
    assign data_w = shreg >> shamt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            state     <= IDLE;
            div_cnt   <= '0;
            div_l     <= '0;
            bits_l    <= 2'd0;
            par_l     <= 2'd0;
            phase     <= 4'd0;
            s7        <= 1'b1;
            s8        <= 1'b1;
            bit_idx   <= 3'd0;
            shreg     <= 8'h00;
            par_acc   <= 1'b0;
            any_one   <= 1'b0;
            push      <= 1'b0;
            push_word <= '0;
        end else begin
            sync1 <= rx_serial;
            sync2 <= sync1;
            push  <= 1'b0;
            if (state != IDLE) begin
                if (tick) begin
                    div_cnt <= div_l;
                    phase   <= phase + 4'd1;
                    if (phase == 4'd7) s7 <= sync2;
                    if (phase == 4'd8) s8 <= sync2;
                end else begin
                    div_cnt <= div_cnt - 1'b1;
                end
            end
            case (state)
                IDLE: if (!sync2) begin
                    div_cnt <= cfg_div;
                    div_l   <= cfg_div;
                    bits_l  <= cfg_bits;
                    par_l   <= cfg_par;
                    phase   <= 4'd0;
                    bit_idx <= 3'd0;
                    par_acc <= 1'b0;
                    any_one <= 1'b0;
                    state   <= START;
                end
                START: if (mid) state <= maj ? IDLE : DATA;
                DATA: if (mid) begin
                    shreg   <= {maj, shreg[7:1]};
                    par_acc <= par_acc ^ maj;
                    any_one <= any_one | maj;
                    bit_idx <= bit_idx + 3'd1;
                    if (bit_idx == {1'b1, bits_l})
                        state <= par_l[1] ? PARITY : STOP;
                end
                PARITY: if (mid) begin
                    par_acc <= par_acc ^ maj;
                    any_one <= any_one | maj;
                    state   <= STOP;
                end
                STOP: if (mid) begin
                    push <= 1'b1;
                    if (!any_one && !maj) begin
                        push_word <= {8'h00, 1'b1, 1'b1, 1'b0};
                        state     <= BRKWAIT;
                    end else begin
                        push_word <= {data_w, 1'b0, ~maj, par_l[1] & (par_acc ^ par_l[0])};
                        state     <= IDLE;
                    end
                end
                BRKWAIT: if (sync2) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    logic [10:0]        mem [2**FIFO_AW];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic               full, do_pop, do_push;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH);
    assign do_pop  = rd_en && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_word;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
            // set wins over a same-cycle clear
            if (push && full && !do_pop) overrun <= 1'b1;
            else if (ovr_clr)            overrun <= 1'b0;
        end
    end

    always_comb begin
        {rd_dat, rd_brk, rd_ferr, rd_perr} = '0;
        if (!empty) {rd_dat, rd_brk, rd_ferr, rd_perr} = mem[rd_ptr];
    end

endmodule

// File: tb/tb_acia_rx_fifo.sv
// tb/tb_acia_rx_fifo.sv - directed self-checking bench for acia_rx_fifo
module tb_acia_rx_fifo;

    localparam int AW  = 2;
    localparam int BIT = 128;   // cfg_div=7 -> 8 clk/tick, 16 ticks/bit

    logic        clk = 1'b0;
    logic        rst_n, rx_serial, rd_en, ovr_clr;
    logic [15:0] cfg_div;
    logic [1:0]  cfg_bits, cfg_par;
    logic [7:0]  rd_dat;
    logic        rd_ferr, rd_perr, rd_brk, empty, overrun;
    logic [AW:0] count;

    int checks = 0;
    int errors = 0;

    acia_rx_fifo #(.DIVW(16), .FIFO_AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .rx_serial(rx_serial), .cfg_div(cfg_div),
        .cfg_bits(cfg_bits), .cfg_par(cfg_par), .rd_en(rd_en), .rd_dat(rd_dat),
        .rd_ferr(rd_ferr), .rd_perr(rd_perr), .rd_brk(rd_brk), .empty(empty),
        .count(count), .overrun(overrun), .ovr_clr(ovr_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // dip=1 pulls the line low for one tick near the bit centre
    task automatic send_bit(input logic b, input bit dip);
        rx_serial = b;
        if (dip) begin
            wait_clk(70); rx_serial = 1'b0;
            wait_clk(8);  rx_serial = b;
            wait_clk(BIT - 78);
        end else begin
            wait_clk(BIT);
        end
    endtask

    task automatic send(input logic [7:0] d, input int nb, input bit pen, input logic pb,
                        input logic stop, input int dip_idx);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < nb; i++) send_bit(d[i], dip_idx == i);
        if (pen) send_bit(pb, 1'b0);
        send_bit(stop, 1'b0);
        send_bit(1'b1, 1'b0);
    endtask

    task automatic pop;
        rd_en = 1'b1; wait_clk(1); rd_en = 1'b0; wait_clk(1);
    endtask

    task automatic chk_head(input string tag, input logic [7:0] d, input logic brk,
                            input logic ferr, input logic perr);
        chk({tag, "_empty"}, 32'(empty), 32'd0);
        chk({tag, "_dat"},   32'(rd_dat), 32'(d));
        chk({tag, "_flags"}, {29'd0, rd_brk, rd_ferr, rd_perr}, {29'd0, brk, ferr, perr});
    endtask

    initial begin
        rst_n = 1'b0; rx_serial = 1'b1; rd_en = 1'b0; ovr_clr = 1'b0;
        cfg_div = 16'd7; cfg_bits = 2'd3; cfg_par = 2'b00;
        wait_clk(3);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_ovr", 32'(overrun), 32'd0);
        chk("rst_out", {21'd0, rd_dat, rd_brk, rd_ferr, rd_perr}, 32'd0);
        rst_n = 1'b1;
        wait_clk(20);

        // 8N1 0xA5
        send(8'hA5, 8, 1'b0, 1'b0, 1'b1, -1);
        chk_head("t1", 8'hA5, 1'b0, 1'b0, 1'b0);
        chk("t1_count", 32'(count), 32'd1);
        pop();
        chk("t1_empty_after", 32'(empty), 32'd1);

        // 7E1 0x41: two ones, even parity bit 0; then the wrong parity bit
        cfg_bits = 2'd2; cfg_par = 2'b10;
        send(8'h41, 7, 1'b1, 1'b0, 1'b1, -1);
        send(8'h41, 7, 1'b1, 1'b1, 1'b1, -1);
        chk("t2_count", 32'(count), 32'd2);
        chk_head("t2a", 8'h41, 1'b0, 1'b0, 1'b0);
        pop();
        chk_head("t2b", 8'h41, 1'b0, 1'b0, 1'b1);
        pop();

        // framing error, then break
        cfg_bits = 2'd3; cfg_par = 2'b00;
        send(8'h55, 8, 1'b0, 1'b0, 1'b0, -1);
        wait_clk(BIT);
        chk("t3_count", 32'(count), 32'd1);
        chk_head("t3f", 8'h55, 1'b0, 1'b1, 1'b0);
        pop();
        rx_serial = 1'b0;
        wait_clk(30 * BIT);
        rx_serial = 1'b1;
        wait_clk(2 * BIT);
        chk("t3_brk_count", 32'(count), 32'd1);
        chk_head("t3b", 8'h00, 1'b1, 1'b1, 1'b0);
        pop();
        send(8'h5A, 8, 1'b0, 1'b0, 1'b1, -1);
        chk_head("t3n", 8'h5A, 1'b0, 1'b0, 1'b0);
        pop();

        // overrun: five chars into a four-deep FIFO
        send(8'h11, 8, 1'b0, 1'b0, 1'b1, -1);
        send(8'h22, 8, 1'b0, 1'b0, 1'b1, -1);
        send(8'h33, 8, 1'b0, 1'b0, 1'b1, -1);
        send(8'h44, 8, 1'b0, 1'b0, 1'b1, -1);
        chk("t4_ovr_before", 32'(overrun), 32'd0);
        send(8'h55, 8, 1'b0, 1'b0, 1'b1, -1);
        chk("t4_count", 32'(count), 32'd4);
        chk("t4_ovr", 32'(overrun), 32'd1);
        chk_head("t4a", 8'h11, 1'b0, 1'b0, 1'b0); pop();
        chk_head("t4b", 8'h22, 1'b0, 1'b0, 1'b0); pop();
        chk_head("t4c", 8'h33, 1'b0, 1'b0, 1'b0); pop();
        chk_head("t4d", 8'h44, 1'b0, 1'b0, 1'b0); pop();
        chk("t4_empty", 32'(empty), 32'd1);
        chk("t4_ovr_held", 32'(overrun), 32'd1);
        ovr_clr = 1'b1; wait_clk(1); ovr_clr = 1'b0; wait_clk(1);
        chk("t4_ovr_clr", 32'(overrun), 32'd0);

        // short low glitches on idle line
        rx_serial = 1'b0; wait_clk(8);  rx_serial = 1'b1; wait_clk(3 * BIT);
        rx_serial = 1'b0; wait_clk(24); rx_serial = 1'b1; wait_clk(3 * BIT);
        rx_serial = 1'b0; wait_clk(48); rx_serial = 1'b1; wait_clk(3 * BIT);
        chk("t5_glitch_count", 32'(count), 32'd0);
        send(8'hFF, 8, 1'b0, 1'b0, 1'b1, 3);
        chk("t5_dip_count", 32'(count), 32'd1);
        chk_head("t5d", 8'hFF, 1'b0, 1'b0, 1'b0);
        pop();

        // reset mid-char with a queued entry
        send(8'h77, 8, 1'b0, 1'b0, 1'b1, -1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        rst_n = 1'b0; rx_serial = 1'b1;
        wait_clk(2);
        chk("t6_rst_empty", 32'(empty), 32'd1);
        chk("t6_rst_count", 32'(count), 32'd0);
        chk("t6_rst_out", {21'd0, rd_dat, rd_brk, rd_ferr, rd_perr}, 32'd0);
        rst_n = 1'b1;
        wait_clk(BIT);
        send(8'h3C, 8, 1'b0, 1'b0, 1'b1, -1);
        chk("t6_count", 32'(count), 32'd1);
        chk_head("t6a", 8'h3C, 1'b0, 1'b0, 1'b0);
        pop();
        cfg_bits = 2'd0;
        send(8'h1F, 5, 1'b0, 1'b0, 1'b1, -1);
        chk_head("t6b", 8'h1F, 1'b0, 1'b0, 1'b0);
        pop();
        chk("t6_final_empty", 32'(empty), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
